// File: rtl/bus_drive_pkg.sv
// Shared types and constants for the bus drive decoder.
// No logic; no latency; no backpressure.
package bus_drive_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        TURN
    } state_t;

    localparam int DEF_N_OUT  = 32;
    localparam int DEF_CODE_W = 5;
    localparam int TURN_W     = 3;

endpackage

// File: rtl/dec_5_32.sv
// Combinational code to one-hot decoder; out-of-range codes give all-zero.
// Zero latency; no backpressure.
module dec_5_32
    import bus_drive_pkg::*;
#(
    parameter int N_OUT  = DEF_N_OUT,
    parameter int CODE_W = DEF_CODE_W
) (
    input  logic [CODE_W-1:0] code,
    output logic [N_OUT-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (32'(code) == i) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_drive_decoder.sv
// Registered code to one-hot bus-drive enable with hold-until-release and turnaround gap.
// Latency: drive valid one cycle after req is accepted.
// Backpressure: ready is low while driving or in turnaround; requests then are dropped.
// Optional BUS_DRIVE_TIMEOUT_EN forces a release (with err) after TIMEOUT drive cycles.
// The release input is named release_req because release is a reserved word.
module bus_drive_decoder
    import bus_drive_pkg::*;
#(
    parameter int N_OUT       = DEF_N_OUT,
    parameter int CODE_W      = DEF_CODE_W,
    parameter int TURN_CYCLES = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req,
    input  logic [CODE_W-1:0] code,
    input  logic              release_req,
    output logic              ready,
    output logic [N_OUT-1:0]  drive,
    output logic              active,
    output logic [CODE_W-1:0] active_code,
    output logic              err
);

    if (N_OUT < 2 || N_OUT > 32 || N_OUT > (1 << CODE_W)) begin : g_bad_n_out
        $error("bus_drive_decoder: N_OUT out of range");
    end
    if (TURN_CYCLES < 0 || TURN_CYCLES > 7) begin : g_bad_turn
        $error("bus_drive_decoder: TURN_CYCLES out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_drive_decoder: TIMEOUT out of range");
    end

    state_t             state;
    logic [TURN_W-1:0]  turn_cnt;
    logic [N_OUT-1:0]   dec_onehot;
    logic               code_legal;
    logic               timeout_hit;
    logic               end_drive;

    dec_5_32 #(
        .N_OUT  (N_OUT),
        .CODE_W (CODE_W)
    ) u_dec (
        .code   (code),
        .onehot (dec_onehot)
    );

    // The decoder already zeroes out-of-range codes, so any set bit means legal.
    assign code_legal = |dec_onehot;
    assign ready      = (state == IDLE) & ~clear;

`ifdef BUS_DRIVE_TIMEOUT_EN
    logic [7:0] drive_cnt;

    assign timeout_hit = (state == DRIVE) && (drive_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (clear || state != DRIVE) begin
            drive_cnt <= '0;
        end else begin
            drive_cnt <= drive_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign end_drive = release_req | timeout_hit;

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            turn_cnt    <= '0;
            drive       <= '0;
            active      <= 1'b0;
            active_code <= '0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (code_legal) begin
                            drive       <= dec_onehot;
                            active      <= 1'b1;
                            active_code <= code;
                            state       <= DRIVE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    // A real release wins over a timeout, so err only flags a forced one.
                    if (end_drive) begin
                        drive       <= '0;
                        active      <= 1'b0;
                        active_code <= '0;
                        err         <= timeout_hit & ~release_req;
                        if (TURN_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state    <= TURN;
                            turn_cnt <= TURN_W'(TURN_CYCLES - 1);
                        end
                    end
                end
                TURN: begin
                    if (turn_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    drive       <= '0;
                    active      <= 1'b0;
                    active_code <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_drive_decoder.sv
// Directed self-checking bench for bus_drive_decoder (N_OUT=32 and N_OUT=24 instances).
module tb_bus_drive_decoder;

    logic        clock = 1'b0;
    logic        clear = 1'b1;

    logic        req = 1'b0;
    logic [4:0]  code = '0;
    logic        release_req = 1'b0;
    logic        ready, active, err;
    logic [31:0] drive;
    logic [4:0]  active_code;

    logic        b_req = 1'b0;
    logic [4:0]  b_code = '0;
    logic        b_release = 1'b0;
    logic        b_ready, b_active, b_err;
    logic [23:0] b_drive;
    logic [4:0]  b_active_code;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clock = ~clock;

    bus_drive_decoder #(.N_OUT(32), .CODE_W(5), .TURN_CYCLES(1), .TIMEOUT(4)) dut (
        .clock(clock), .clear(clear), .req(req), .code(code), .release_req(release_req),
        .ready(ready), .drive(drive), .active(active), .active_code(active_code), .err(err)
    );

    bus_drive_decoder #(.N_OUT(24), .CODE_W(5), .TURN_CYCLES(1), .TIMEOUT(4)) dut24 (
        .clock(clock), .clear(clear), .req(b_req), .code(b_code), .release_req(b_release),
        .ready(b_ready), .drive(b_drive), .active(b_active), .active_code(b_active_code), .err(b_err)
    );

    task automatic tick;
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(drive) || active !== |drive || !$onehot0(b_drive) || b_active !== |b_drive) begin
                errors++;
                $display("FAIL invariant drive=%h active=%b b_drive=%h b_active=%b (want one-hot-or-zero, active=|drive)",
                         drive, active, b_drive, b_active);
            end
        end
    end

    task automatic test_reset;
        clear = 1'b1;
        tick; tick;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (drive !== 32'h0) begin errors++; $display("FAIL reset_drive got %h want 0", drive); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
        checks++; if (active_code !== 5'd0) begin errors++; $display("FAIL reset_code got %0d want 0", active_code); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (b_drive !== 24'h0) begin errors++; $display("FAIL reset_b_drive got %h want 0", b_drive); end
        clear = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", ready); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready_after got %b want 1", b_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        req = 1'b1; code = 5'd5;
        tick;
        req = 1'b0;
        checks++; if (drive !== 32'h0000_0020) begin errors++; $display("FAIL basic_drive got %h want 00000020", drive); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL basic_active got %b want 1", active); end
        checks++; if (active_code !== 5'd5) begin errors++; $display("FAIL basic_code got %0d want 5", active_code); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready got %b want 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
    endtask

    task automatic test_release_turn;
        tick;
        checks++; if (drive !== 32'h0000_0020) begin errors++; $display("FAIL hold_drive got %h want 00000020", drive); end
        release_req = 1'b1;
        tick;
        checks++; if (drive !== 32'h0) begin errors++; $display("FAIL release_drive got %h want 0", drive); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL release_active got %b want 0", active); end
        checks++; if (active_code !== 5'd0) begin errors++; $display("FAIL release_code got %0d want 0", active_code); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL turn_ready got %b want 0", ready); end
        tick;
        release_req = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL turn_done_ready got %b want 1", ready); end
        req = 1'b1; code = 5'd31;
        tick;
        req = 1'b0;
        checks++; if (drive !== 32'h8000_0000) begin errors++; $display("FAIL code31_drive got %h want 80000000", drive); end
        checks++; if (active_code !== 5'd31) begin errors++; $display("FAIL code31_code got %0d want 31", active_code); end
        release_req = 1'b1;
        tick;
        release_req = 1'b0;
        tick;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL code31_idle_ready got %b want 1", ready); end
    endtask

    task automatic test_code_zero;
        req = 1'b1; code = 5'd0;
        tick;
        req = 1'b0;
        checks++; if (drive !== 32'h0000_0001) begin errors++; $display("FAIL code0_drive got %h want 00000001", drive); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL code0_active got %b want 1", active); end
        release_req = 1'b1;
        tick;
        release_req = 1'b0;
        tick;
    endtask

    task automatic test_release_with_req;
        req = 1'b1; code = 5'd3;
        tick;
        req = 1'b0;
        checks++; if (drive !== 32'h0000_0008) begin errors++; $display("FAIL rr_drive3 got %h want 00000008", drive); end
        release_req = 1'b1; req = 1'b1; code = 5'd9;
        tick;
        release_req = 1'b0; req = 1'b0;
        checks++; if (drive !== 32'h0) begin errors++; $display("FAIL rr_drive_after got %h want 0", drive); end
        checks++; if (active_code !== 5'd0) begin errors++; $display("FAIL rr_code_after got %0d want 0", active_code); end
        tick;
        checks++; if (drive !== 32'h0) begin errors++; $display("FAIL rr_no_code9 got %h want 0", drive); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rr_ready got %b want 1", ready); end
    endtask

    task automatic test_clear_mid_drive;
        req = 1'b1; code = 5'd12;
        tick;
        req = 1'b0;
        checks++; if (drive !== 32'h0000_1000) begin errors++; $display("FAIL clr_drive12 got %h want 00001000", drive); end
        clear = 1'b1;
        tick;
        checks++; if (drive !== 32'h0) begin errors++; $display("FAIL clr_drive got %h want 0", drive); end
        checks++; if (active_code !== 5'd0) begin errors++; $display("FAIL clr_code got %0d want 0", active_code); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clr_ready_high got %b want 0", ready); end
        clear = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clr_ready_drop got %b want 1", ready); end
        tick;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clr_no_turn got %b want 1", ready); end
    endtask

    task automatic test_illegal_code;
        b_req = 1'b1; b_code = 5'd27;
        tick;
        b_req = 1'b0;
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL ill27_err got %b want 1", b_err); end
        checks++; if (b_drive !== 24'h0) begin errors++; $display("FAIL ill27_drive got %h want 0", b_drive); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL ill27_ready got %b want 1", b_ready); end
        tick;
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL ill27_err_pulse got %b want 0", b_err); end
        b_req = 1'b1; b_code = 5'd24;
        tick;
        b_req = 1'b0;
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL ill24_err got %b want 1", b_err); end
        checks++; if (b_drive !== 24'h0) begin errors++; $display("FAIL ill24_drive got %h want 0", b_drive); end
        b_req = 1'b1; b_code = 5'd23;
        tick;
        b_req = 1'b0;
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL leg23_err got %b want 0", b_err); end
        checks++; if (b_drive !== 24'h80_0000) begin errors++; $display("FAIL leg23_drive got %h want 800000", b_drive); end
        checks++; if (b_active_code !== 5'd23) begin errors++; $display("FAIL leg23_code got %0d want 23", b_active_code); end
        b_release = 1'b1;
        tick;
        b_release = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        req = 1'b1; code = 5'd7;
        tick;
        req = 1'b0;
`ifdef BUS_DRIVE_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (drive !== 32'h80 || err !== 1'b0) begin
                errors++; $display("FAIL to_hold cycle %0d got drive=%h err=%b want 00000080/0", i, drive, err);
            end
            tick;
        end
        checks++; if (drive !== 32'h0) begin errors++; $display("FAIL to_drive got %h want 0", drive); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err); end
        tick;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b want 0", err); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL to_ready got %b want 1", ready); end
`else
        for (int i = 0; i < 110; i++) begin
            checks++;
            if (drive !== 32'h80 || err !== 1'b0) begin
                errors++; $display("FAIL hold_long cycle %0d got drive=%h err=%b want 00000080/0", i, drive, err);
            end
            tick;
        end
        release_req = 1'b1;
        tick;
        release_req = 1'b0;
        checks++; if (drive !== 32'h0) begin errors++; $display("FAIL hold_rel_drive got %h want 0", drive); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_rel_err got %b want 0", err); end
        tick;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold_rel_ready got %b want 1", ready); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_release_turn;
        test_code_zero;
        test_release_with_req;
        test_clear_mid_drive;
        test_illegal_code;
        test_timeout;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
